// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin codes, coin values and payout state type shared with the vending FSM
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_2RS  = 2'b01,
        COIN_5RS  = 2'b10,
        COIN_10RS = 2'b11
    } coin_e;

    typedef enum logic [2:0] {
        PAY_IDLE,
        PAY_SELECT,
        PAY_FIRE,
        PAY_WAIT_ACK,
        PAY_DONE
    } pay_state_e;

    function automatic logic [3:0] coin_value(input coin_e c);
        case (c)
            COIN_2RS:  return 4'd2;
            COIN_5RS:  return 4'd5;
            COIN_10RS: return 4'd10;
            default:   return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_payout_ctrl_if.sv
// rtl/change_payout_ctrl_if.sv - request and hopper handshake bundle of the payout controller
interface change_payout_ctrl_if #(
    parameter int AMT_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [AMT_W-1:0] req_amount;
    logic             hop_fire;
    logic [1:0]       hop_coin;
    logic             hop_ack;

    modport master (
        output req_valid, req_amount, hop_ack,
        input  req_ready, hop_fire, hop_coin
    );

    modport slave (
        input  req_valid, req_amount, hop_ack,
        output req_ready, hop_fire, hop_coin
    );
endinterface

// File: rtl/payout_coin_select.sv
// rtl/payout_coin_select.sv - picks the largest coin that leaves a payable remainder
module payout_coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W = 8,
    parameter int INV_W = 6
) (
    input  logic [AMT_W-1:0] rem,
    input  logic [INV_W-1:0] inv2,
    input  logic [INV_W-1:0] inv5,
    input  logic [INV_W-1:0] inv10,
    output coin_e            coin,
    output logic             none
);
    logic [AMT_W-1:0] left10;
    logic [AMT_W-1:0] left5;
    logic             elig10;
    logic             elig5;
    logic             elig2;

    // A remainder of 1 or 3 can never be paid with 2s, so 10 and 5 must not leave one.
    assign left10 = rem - AMT_W'(10);
    assign left5  = rem - AMT_W'(5);

    assign elig10 = (inv10 != '0) && (rem >= AMT_W'(10)) &&
                    (left10 != AMT_W'(1)) && (left10 != AMT_W'(3));
    assign elig5  = (inv5 != '0) && (rem >= AMT_W'(5)) &&
                    (left5 != AMT_W'(1)) && (left5 != AMT_W'(3));
    assign elig2  = (inv2 != '0) && (rem >= AMT_W'(2));

    // Priority: largest eligible denomination first
    always_comb begin
        coin = COIN_NONE;
        if (elig10)
            coin = COIN_10RS;
        else if (elig5)
            coin = COIN_5RS;
        else if (elig2)
            coin = COIN_2RS;
        none = (coin == COIN_NONE);
    end
endmodule

// File: rtl/change_payout_ctrl.sv
// rtl/change_payout_ctrl.sv - coin hopper payout sequencer with inventory; option INV_LOW_ALARM_EN
module change_payout_ctrl
    import vend_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int INV_W       = 6,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    change_payout_ctrl_if.slave bus,
    input  logic                inv_load,
    input  logic [1:0]          inv_coin_sel,
    input  logic [INV_W-1:0]    inv_load_val,
    output logic                done,
    output logic [AMT_W-1:0]    paid_total,
    output logic [AMT_W-1:0]    shortfall,
    output logic                fault,
    output logic [INV_W-1:0]    inv2,
    output logic [INV_W-1:0]    inv5,
    output logic [INV_W-1:0]    inv10
`ifdef INV_LOW_ALARM_EN
    ,
    output logic [2:0]          inv_low
`endif
);
    localparam int              TMR_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(ACK_TIMEOUT);

    pay_state_e       state;
    pay_state_e       state_nxt;
    logic [AMT_W-1:0] rem;
    logic [TMR_W-1:0] timer;
    coin_e            sel_coin;
    coin_e            pick_coin;
    logic             pick_none;
    logic [AMT_W-1:0] coin_amt;
    logic             ack_ok;
    logic             ack_expired;

    assign coin_amt    = AMT_W'(coin_value(sel_coin));
    assign ack_ok      = (state == PAY_WAIT_ACK) && bus.hop_ack;
    // An ack arriving on the last allowed cycle still counts as a paid coin.
    assign ack_expired = (state == PAY_WAIT_ACK) && !bus.hop_ack && (timer == TMR_MAX);

    payout_coin_select #(
        .AMT_W (AMT_W),
        .INV_W (INV_W)
    ) u_select (
        .rem   (rem),
        .inv2  (inv2),
        .inv5  (inv5),
        .inv10 (inv10),
        .coin  (pick_coin),
        .none  (pick_none)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= PAY_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.hop_fire  = 1'b0;
        bus.hop_coin  = COIN_NONE;
        done          = 1'b0;
        case (state)
            PAY_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_nxt = PAY_SELECT;
            end
            PAY_SELECT: begin
                if (pick_none)
                    state_nxt = PAY_DONE;
                else
                    state_nxt = PAY_FIRE;
            end
            PAY_FIRE: begin
                bus.hop_fire = 1'b1;
                bus.hop_coin = sel_coin;
                state_nxt    = PAY_WAIT_ACK;
            end
            PAY_WAIT_ACK: begin
                bus.hop_coin = sel_coin;
                if (ack_ok)
                    state_nxt = PAY_SELECT;
                else if (ack_expired)
                    state_nxt = PAY_DONE;
            end
            PAY_DONE: begin
                done      = 1'b1;
                state_nxt = PAY_IDLE;
            end
            default: state_nxt = PAY_IDLE;
        endcase
    end

    // Remaining amount, ack timer, coin selection and payout results
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem        <= '0;
            timer      <= '0;
            sel_coin   <= COIN_NONE;
            paid_total <= '0;
            shortfall  <= '0;
            fault      <= 1'b0;
        end else begin
            case (state)
                PAY_IDLE: begin
                    if (bus.req_valid) begin
                        rem        <= bus.req_amount;
                        paid_total <= '0;
                        shortfall  <= '0;
                        fault      <= 1'b0;
                    end
                end
                PAY_SELECT: begin
                    if (pick_none)
                        shortfall <= rem;
                    else
                        sel_coin <= pick_coin;
                end
                PAY_FIRE: timer <= '0;
                PAY_WAIT_ACK: begin
                    if (ack_ok) begin
                        rem        <= rem - coin_amt;
                        paid_total <= paid_total + coin_amt;
                    end else if (ack_expired) begin
                        fault     <= 1'b1;
                        shortfall <= rem;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Inventory: loads only while idle, one coin removed per confirmed ejection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inv2  <= '0;
            inv5  <= '0;
            inv10 <= '0;
        end else if ((state == PAY_IDLE) && inv_load) begin
            case (inv_coin_sel)
                2'b01:   inv2  <= inv_load_val;
                2'b10:   inv5  <= inv_load_val;
                2'b11:   inv10 <= inv_load_val;
                default: ;
            endcase
        end else if (ack_ok) begin
            case (sel_coin)
                COIN_2RS:  if (inv2 != '0)  inv2  <= inv2 - 1'b1;
                COIN_5RS:  if (inv5 != '0)  inv5  <= inv5 - 1'b1;
                COIN_10RS: if (inv10 != '0) inv10 <= inv10 - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef INV_LOW_ALARM_EN
    assign inv_low = reset_n ? {(inv10 < INV_W'(4)), (inv5 < INV_W'(4)), (inv2 < INV_W'(4))} : 3'b000;
`else
    // Low-inventory alarm not built in this configuration.
`endif
endmodule

// File: tb/tb_change_payout_ctrl.sv
// tb/tb_change_payout_ctrl.sv - scoreboard bench for change_payout_ctrl
module tb_change_payout_ctrl;
    import vend_pkg::*;

    localparam int AMT_W       = 8;
    localparam int INV_W       = 6;
    localparam int ACK_TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    change_payout_ctrl_if #(.AMT_W(AMT_W)) bus ();

    logic             inv_load = 1'b0;
    logic [1:0]       inv_coin_sel = 2'b00;
    logic [INV_W-1:0] inv_load_val = '0;
    logic             done;
    logic             fault;
    logic [AMT_W-1:0] paid_total;
    logic [AMT_W-1:0] shortfall;
    logic [INV_W-1:0] inv2;
    logic [INV_W-1:0] inv5;
    logic [INV_W-1:0] inv10;
`ifdef INV_LOW_ALARM_EN
    logic [2:0]       inv_low;
`endif

    logic resp_ack = 1'b0;
    logic man_ack  = 1'b0;
    assign bus.hop_ack = resp_ack | man_ack;

    change_payout_ctrl #(
        .AMT_W       (AMT_W),
        .INV_W       (INV_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .inv_load     (inv_load),
        .inv_coin_sel (inv_coin_sel),
        .inv_load_val (inv_load_val),
        .done         (done),
        .paid_total   (paid_total),
        .shortfall    (shortfall),
        .fault        (fault),
        .inv2         (inv2),
        .inv5         (inv5),
        .inv10        (inv10)
`ifdef INV_LOW_ALARM_EN
        ,
        .inv_low      (inv_low)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int paid;
        int short_amt;
        int flt;
    } res_t;

    res_t exp_res_q[$];
    int   exp_coin_q[$];

    // Hopper model: ack ack_delay WAIT_ACK cycles after a fire; negative means never
    int ack_delay = 0;
    bit resp_wait = 1'b0;
    int resp_cnt  = 0;
    always @(negedge clk) begin
        if (bus.hop_fire) begin
            resp_wait = (ack_delay >= 0);
            resp_cnt  = ack_delay;
            resp_ack  = 1'b0;
        end else if (resp_wait) begin
            if (resp_cnt == 0) begin
                resp_ack  = 1'b1;
                resp_wait = 1'b0;
            end else begin
                resp_cnt--;
                resp_ack = 1'b0;
            end
        end else begin
            resp_ack = 1'b0;
        end
    end

    // Scoreboard: compare fired coins and payout results against expectations
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.hop_fire) begin
                check_eq("busy_ready", bus.req_ready, 0);
                if (exp_coin_q.size() == 0)
                    check_eq("unexpected_fire", 1, 0);
                else
                    check_eq("coin", bus.hop_coin, exp_coin_q.pop_front());
            end
            if (done) begin
                if (exp_res_q.size() == 0) begin
                    check_eq("unexpected_done", 1, 0);
                end else begin
                    res_t r;
                    r = exp_res_q.pop_front();
                    check_eq("paid_total", paid_total, r.paid);
                    check_eq("shortfall", shortfall, r.short_amt);
                    check_eq("fault", fault, r.flt);
                end
            end
        end
    end

    task automatic load_inv(input logic [1:0] sel, input int val);
        @(posedge clk); #1;
        inv_load     = 1'b1;
        inv_coin_sel = sel;
        inv_load_val = INV_W'(val);
        @(posedge clk); #1;
        inv_load = 1'b0;
    endtask

    task automatic expect_result(input int paid, input int short_amt, input int flt);
        res_t r;
        r.paid      = paid;
        r.short_amt = short_amt;
        r.flt       = flt;
        exp_res_q.push_back(r);
    endtask

    task automatic run_pay(input int amount, input int e2, input int e5, input int e10,
                           input int exp_lat, input logic [1:0] acc_sel, input int acc_val,
                           input bit busy_load);
        int lat;
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_amount = AMT_W'(amount);
        if (acc_sel != 2'b00) begin
            inv_load     = 1'b1;
            inv_coin_sel = acc_sel;
            inv_load_val = INV_W'(acc_val);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        inv_load      = 1'b0;
        check_eq("accept_clr_fault", fault, 0);
        check_eq("accept_clr_paid", paid_total, 0);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy_load && lat == 4) begin
                inv_load     = 1'b1;
                inv_coin_sel = 2'b11;
                inv_load_val = INV_W'(9);
            end else if (busy_load && lat == 5) begin
                inv_load = 1'b0;
            end
            if (done) break;
        end
        if (!done)
            check_eq("done_timeout", 0, 1);
        else if (exp_lat >= 0)
            check_eq("latency", lat, exp_lat);
        @(posedge clk); #1;
        check_eq("done_one_cycle", done, 0);
        check_eq("ready_after", bus.req_ready, 1);
        check_eq("inv2", inv2, e2);
        check_eq("inv5", inv5, e5);
        check_eq("inv10", inv10, e10);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_amount = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", bus.req_ready, 1);
        check_eq("rst_fire", bus.hop_fire, 0);
        check_eq("rst_coin", bus.hop_coin, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_paid", paid_total, 0);
        check_eq("rst_short", shortfall, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_inv", {inv2, inv5, inv10}, 0);
        reset_n = 1'b1;

        // 18 with 5/5/5: 10 then four 2s
        load_inv(2'b11, 5); load_inv(2'b10, 5); load_inv(2'b01, 5);
        ack_delay = 0;
        exp_coin_q.push_back(COIN_10RS);
        repeat (4) exp_coin_q.push_back(COIN_2RS);
        expect_result(18, 0, 0);
        run_pay(18, 1, 5, 4, -1, 2'b00, 0, 1'b0);

        // 11 with 5/5/5: 10 would leave 1, so 5 then three 2s
        load_inv(2'b11, 5); load_inv(2'b10, 5); load_inv(2'b01, 5);
        ack_delay = 1;
        exp_coin_q.push_back(COIN_5RS);
        repeat (3) exp_coin_q.push_back(COIN_2RS);
        expect_result(11, 0, 0);
        run_pay(11, 2, 4, 5, -1, 2'b00, 0, 1'b0);

        // 7 with only one 2rs coin
        load_inv(2'b11, 0); load_inv(2'b10, 0); load_inv(2'b01, 1);
        exp_coin_q.push_back(COIN_2RS);
        expect_result(2, 5, 0);
        run_pay(7, 0, 0, 0, -1, 2'b00, 0, 1'b0);

        // Unpayable 1 and zero amount: done two cycles after accept
        expect_result(0, 1, 0);
        run_pay(1, 0, 0, 0, 2, 2'b00, 0, 1'b0);
        expect_result(0, 0, 0);
        run_pay(0, 0, 0, 0, 2, 2'b00, 0, 1'b0);

        // Inventory load in the accept cycle is used by this payout
        ack_delay = 0;
        repeat (3) exp_coin_q.push_back(COIN_2RS);
        expect_result(6, 0, 0);
        run_pay(6, 0, 0, 0, -1, 2'b01, 3, 1'b0);

        // Ack withheld: fault, coin not counted, busy load ignored
        load_inv(2'b11, 2);
        ack_delay = -1;
        exp_coin_q.push_back(COIN_10RS);
        expect_result(0, 10, 1);
        run_pay(10, 0, 0, 2, 3 + ACK_TIMEOUT + 1, 2'b00, 0, 1'b1);
        check_eq("fault_sticky", fault, 1);

        // Ack on the expiry cycle wins; next accept clears fault
        ack_delay = ACK_TIMEOUT;
        exp_coin_q.push_back(COIN_10RS);
        expect_result(10, 0, 0);
        run_pay(10, 0, 0, 1, 3 + ACK_TIMEOUT + 2, 2'b00, 0, 1'b0);

        // 13 with 10/5/2 = 1/1/5: 10 would leave 3
        load_inv(2'b10, 1); load_inv(2'b01, 5);
        ack_delay = 2;
        exp_coin_q.push_back(COIN_5RS);
        repeat (4) exp_coin_q.push_back(COIN_2RS);
        expect_result(13, 0, 0);
        run_pay(13, 1, 0, 1, -1, 2'b00, 0, 1'b0);

        // Reset while waiting for ack; late ack must be ignored
        load_inv(2'b01, 3);
        ack_delay = -1;
        exp_coin_q.push_back(COIN_2RS);
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_amount = AMT_W'(4);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (n < 20 && !bus.hop_fire) begin
                @(negedge clk);
                n++;
            end
            if (!bus.hop_fire) check_eq("fire_timeout", 0, 1);
        end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", bus.req_ready, 1);
        check_eq("mid_rst_coin", bus.hop_coin, 0);
        check_eq("mid_rst_inv", {inv2, inv5, inv10}, 0);
        check_eq("mid_rst_paid", paid_total, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        man_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        man_ack = 1'b0;
        check_eq("late_ack_paid", paid_total, 0);
        check_eq("late_ack_inv2", inv2, 0);
        check_eq("late_ack_ready", bus.req_ready, 1);
        check_eq("late_ack_fault", fault, 0);

        check_eq("coin_queue_empty", exp_coin_q.size(), 0);
        check_eq("res_queue_empty", exp_res_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
